// File: rtl/thunderbird_pkg.sv
// Shared types and constants for the thunderbird turn-signal slice.
// Holds the arbiter mode encoding and default sequence timing.
package thunderbird_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;

    localparam int SEQ_TICKS_DEF   = 4;
    localparam int FLASH_LIMIT_DEF = 8;

    // Counter width for a count of n states, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_sync_edge.sv
// Two-flop synchronizer for one raw switch input.
// Exposes the synchronized level and a one-cycle rising-edge strobe.
module sw_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // Metastability chain plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;

endmodule

// File: rtl/turn_request_arbiter.sv
// Turns raw stalk/hazard/cancel switches into exclusive left/right commands.
// TURN_AUTO_CANCEL_EN builds the tick counter and auto-cancel path.
module turn_request_arbiter
    import thunderbird_pkg::*;
#(
    parameter int SEQ_TICKS   = SEQ_TICKS_DEF,
    parameter int FLASH_LIMIT = FLASH_LIMIT_DEF
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    input  logic       cancel_sw,
    output logic       left,
    output logic       right,
    output logic [1:0] mode,
    output logic       expired
);

    localparam int TOTAL = SEQ_TICKS * FLASH_LIMIT;
    localparam int CW    = cnt_width(TOTAL);

    logic  l_rise;
    logic  r_rise;
    logic  c_rise;
    logic  haz;
    logic  l_lvl;
    logic  r_lvl;
    logic  c_lvl;
    logic  h_rise;

    mode_t state;
    mode_t nstate;
    logic  turning;
    logic  enter;
    logic  fire;
    logic  ac_hit;

    sw_sync_edge u_left (
        .clk   (Clk),
        .rst   (reset),
        .d     (left_sw),
        .level (l_lvl),
        .rise  (l_rise)
    );

    sw_sync_edge u_right (
        .clk   (Clk),
        .rst   (reset),
        .d     (right_sw),
        .level (r_lvl),
        .rise  (r_rise)
    );

    sw_sync_edge u_cancel (
        .clk   (Clk),
        .rst   (reset),
        .d     (cancel_sw),
        .level (c_lvl),
        .rise  (c_rise)
    );

    sw_sync_edge u_hazard (
        .clk   (Clk),
        .rst   (reset),
        .d     (hazard_sw),
        .level (haz),
        .rise  (h_rise)
    );

    assign turning = (state == LEFT) || (state == RIGHT);

    // Next mode: hazard level, then cancel, then stalk edges, then timeout.
    always_comb begin
        nstate = state;
        enter  = 1'b0;
        fire   = 1'b0;
        if (haz) begin
            nstate = HAZARD;
        end else if (state == HAZARD) begin
            nstate = IDLE;
        end else if (c_rise && turning) begin
            nstate = IDLE;
        end else if (l_rise && !r_rise) begin
            if (state == LEFT) begin
                nstate = IDLE;
            end else begin
                nstate = LEFT;
                enter  = 1'b1;
            end
        end else if (r_rise && !l_rise) begin
            if (state == RIGHT) begin
                nstate = IDLE;
            end else begin
                nstate = RIGHT;
                enter  = 1'b1;
            end
        end else if (ac_hit) begin
            nstate = IDLE;
            fire   = 1'b1;
        end
    end

    // Mode register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

`ifdef TURN_AUTO_CANCEL_EN
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          expired_q;

    assign ac_hit = turning && tick && (cnt == LAST);

    // Tick count restarts on every turn entry and idles at zero otherwise.
    always_comb begin
        cnt_n = cnt;
        if (enter || !((nstate == LEFT) || (nstate == RIGHT))) begin
            cnt_n = '0;
        end else if (tick) begin
            cnt_n = cnt + CW'(1);
        end
    end

    // Counter and timeout strobe registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            expired_q <= fire;
        end
    end

    assign expired = expired_q;

    logic unused_ok;
    assign unused_ok = &{l_lvl, r_lvl, c_lvl, h_rise};
`else
    assign ac_hit  = 1'b0;
    assign expired = 1'b0;

    logic unused_ok;
    assign unused_ok = &{l_lvl, r_lvl, c_lvl, h_rise, tick, enter, fire,
                         (TOTAL != 0), (CW != 0)};
`endif

    assign left  = (state == LEFT) || (state == HAZARD);
    assign right = (state == RIGHT) || (state == HAZARD);
    assign mode  = state;

endmodule

// File: doc/turn_request_arbiter.md
# turn_request_arbiter

Sequencing controller placed between the driver switches and the thunderbird tail-light FSM. It turns raw, asynchronous switch inputs into clean, mutually exclusive `left`/`right` commands for the FSM. It handles toggle on/off, direction changes, hazard override and tick-based auto-cancel. It runs on the system clock and uses the clock divider's enable strobe (`clk_en`) as its time base, so the FSM and the auto-cancel count advance at the same rate.

## Interface
- `SEQ_TICKS`, default 4: ticks per full light sequence (OFF, 1, 2, 3 lamps).
- `FLASH_LIMIT`, default 8: full sequences before auto-cancel, ≥1.
- `Clk` input 1: system clock, single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: one-`Clk` strobe from the clock divider.
- `left_sw` input 1: raw left stalk. Asynchronous; a rising edge is a request.
- `right_sw` input 1: raw right stalk. Asynchronous; a rising edge is a request.
- `hazard_sw` input 1: raw hazard switch. Asynchronous; level-sensitive.
- `cancel_sw` input 1: raw cancel button. Asynchronous; a rising edge is a request.
- `left` output 1: drives the FSM `left` input, registered.
- `right` output 1: drives the FSM `right` input, registered.
- `mode` output 2: current state encoding, registered.
- `expired` output 1: one-`Clk` pulse when auto-cancel fires.

## Operation
- Every switch input passes through a 2-flop synchronizer.
- `left_sw`, `right_sw` and `cancel_sw` then pass through a rising-edge detector. `hazard_sw` is used as a synchronized level.
- States and `mode` encoding: IDLE=00, LEFT=01, RIGHT=10, HAZARD=11.
- Outputs per state:
  - IDLE: `left`=0, `right`=0.
  - LEFT: `left`=1, `right`=0.
  - RIGHT: `left`=0, `right`=1.
  - HAZARD: `left`=1, `right`=1.
- Priority, highest first: synchronized hazard level, then cancel edge, then left/right edges, then auto-cancel.
- Hazard:
  - While the synced hazard level is 1, the state is HAZARD from any state.
  - When it falls to 0, the state goes to IDLE. The previous turn is not resumed.
- Cancel edge: in LEFT or RIGHT, go to IDLE. No effect in IDLE or HAZARD.
- Left edge:
  - IDLE → LEFT.
  - LEFT → IDLE (toggle).
  - RIGHT → LEFT (direct switch).
  - Ignored in HAZARD.
- Right edge: mirror of the left edge.
- Left and right edges in the same cycle: both are ignored and the state is unchanged.
- Sequence counter:
  - Width is clog2(SEQ_TICKS*FLASH_LIMIT).
  - Cleared on every entry to LEFT or RIGHT, including direct switches and toggle re-entry.
  - Increments on `tick` only while in LEFT or RIGHT.
  - Holds at 0 in IDLE and HAZARD.
- Auto-cancel: fires when `tick`=1 and the counter equals SEQ_TICKS*FLASH_LIMIT−1. On the next edge the state goes to IDLE, the counter clears and `expired` pulses. Any higher-priority event in the same cycle wins and suppresses `expired`.

## Timing
- Reset values: state IDLE, `left`=0, `right`=0, `mode`=00, `expired`=0; counter and all sync/edge flops 0.
- Request latency: an input stable before edge E0 produces the new `left`/`right`/`mode` after edge E2 (3 `Clk` edges). The same latency applies to hazard assertion and release.
- Edge detection is computed combinationally from sync stage 2 against its registered previous value.
- Auto-cancel: from the entry edge, LEFT/RIGHT lasts exactly SEQ_TICKS*FLASH_LIMIT `tick` strobes. It drops on the `Clk` edge that samples the final tick.
- `expired` is high for exactly the one cycle following that edge.
- `tick` wider than one cycle is illegal; each high cycle counts.
- Reset asserted mid-operation: all outputs drop immediately (asynchronously). Operation resumes from IDLE on the first edge after deassertion.

## Configuration
- `TURN_AUTO_CANCEL_EN` defined: the sequence counter and auto-cancel path are built, and `expired` behaves as above.
- `TURN_AUTO_CANCEL_EN` undefined: the counter is not built, `expired` is tied to 0, and LEFT/RIGHT persist until a toggle, a direction switch, a cancel or hazard.

## Structure
- `thunderbird_pkg` holds the `mode_t` enum (IDLE/LEFT/RIGHT/HAZARD with the encodings above) and the shared constants `SEQ_TICKS_DEF`=4 and `FLASH_LIMIT_DEF`=8.
- The sub-module `sw_sync_edge` contains the 2-flop synchronizer with async reset and exposes both the level and a rising-edge output. It is instantiated 4 times; `hazard_sw` uses only the level output.
- The FSM and counter live in `turn_request_arbiter`.

## Test plan
- Reset, then a `left_sw` rise → `left`=1, `mode`=01 after 3 edges. Second rise → IDLE, `left`=0.
- In LEFT, `right_sw` rise → `mode`=10, `left`=0, `right`=1, counter cleared. `left_sw` and `right_sw` rising in the same cycle from IDLE → `mode` stays 00.
- In RIGHT, assert `hazard_sw` → `mode`=11, `left`=`right`=1. Pulse `cancel_sw` → no change. Release hazard → `mode`=00.
- Defaults with `TURN_AUTO_CANCEL_EN` defined, enter LEFT, apply 32 ticks → `mode`=00 after the 32nd tick and `expired` pulses once. With the macro undefined, 100 ticks → still LEFT.
- Hazard asserted in the same cycle the 32nd tick arrives → HAZARD, `expired`=0.
- Assert `reset` mid-LEFT between clock edges → all outputs 0 immediately. After release, a `left_sw` rise works normally.
